// File: rtl/regfile_2w_scoreboard.sv
// regfile_2w_scoreboard: 2R/2W register file with per-register pending scoreboard and optional write bypass
module regfile_2w_scoreboard #(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 5,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en_a,
    input  logic [ADDR_W-1:0] wr_addr_a,
    input  logic [DATA_W-1:0] wr_data_a,
    input  logic              wr_en_b,
    input  logic [ADDR_W-1:0] wr_addr_b,
    input  logic [DATA_W-1:0] wr_data_b,
    input  logic              claim_en,
    input  logic [ADDR_W-1:0] claim_addr,
    output logic              collision
);
    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pend;
    logic [DEPTH-1:0]  pend_nxt;
    logic              we_a, we_b, cl;

    // Register 0 swallows writes and claims when hardwired to zero, so it can never collide or go busy
    always_comb begin
        we_a = wr_en_a && !(ZERO_REG != 0 && wr_addr_a == '0);
        we_b = wr_en_b && !(ZERO_REG != 0 && wr_addr_b == '0);
        cl   = claim_en && !(ZERO_REG != 0 && claim_addr == '0);
    end

    // One read port: {busy, data}; forwarded writes clear busy unless the same register is re-claimed now
    function automatic logic [DATA_W:0] read_port(input logic [ADDR_W-1:0] ad);
        logic hit_a, hit_b, hit_c;
        hit_a = BYPASS != 0 && we_a && wr_addr_a == ad;
        hit_b = BYPASS != 0 && we_b && wr_addr_b == ad;
        hit_c = cl && claim_addr == ad;
        if (ZERO_REG != 0 && ad == '0) return '0;
        if (hit_b) return {hit_c, wr_data_b};
        if (hit_a) return {hit_c, wr_data_a};
        return {pend[ad], regs[ad]};
    endfunction

    // Combinational operand fetch for both read ports
    always_comb begin
        {rd_busy1, rd_data1} = read_port(rd_addr1);
        {rd_busy2, rd_data2} = read_port(rd_addr2);
    end

    // Scoreboard update: writes retire producers, a claim in the same cycle re-arms the bit
    always_comb begin
        pend_nxt = pend;
        if (we_a) pend_nxt[wr_addr_a] = 1'b0;
        if (we_b) pend_nxt[wr_addr_b] = 1'b0;
        if (cl) pend_nxt[claim_addr] = 1'b1;
    end

    // State: register array (port B written last so it wins), pending bits, collision pulse
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
            pend      <= '0;
            collision <= 1'b0;
        end else begin
            if (we_a) regs[wr_addr_a] <= wr_data_a;
            if (we_b) regs[wr_addr_b] <= wr_data_b;
            pend      <= pend_nxt;
            collision <= we_a && we_b && wr_addr_a == wr_addr_b;
        end
    end
endmodule

// File: tb/tb_regfile_2w_scoreboard.sv
// tb_regfile_2w_scoreboard: directed, table-driven and randomized checks of the scoreboarded register file
module tb_regfile_2w_scoreboard;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [4:0]  ra1, ra2, waa, wab, cla;
    logic [31:0] rd1, rd2, wda, wdb;
    logic        rb1, rb2, wea, web, cle, col;

    logic [2:0]  v_ra1, v_ra2, v_waa, v_wab, v_cla;
    logic [15:0] v_rd1, v_rd2, v_wda, v_wdb;
    logic        v_rb1, v_rb2, v_wea, v_web, v_cle, v_col;

    int checks = 0;
    int errors = 0;

    regfile_2w_scoreboard u0 (
        .clk(clk), .reset(reset),
        .rd_addr1(ra1), .rd_addr2(ra2), .rd_data1(rd1), .rd_data2(rd2),
        .rd_busy1(rb1), .rd_busy2(rb2),
        .wr_en_a(wea), .wr_addr_a(waa), .wr_data_a(wda),
        .wr_en_b(web), .wr_addr_b(wab), .wr_data_b(wdb),
        .claim_en(cle), .claim_addr(cla), .collision(col)
    );

    regfile_2w_scoreboard #(.DATA_W(16), .ADDR_W(3), .ZERO_REG(0), .BYPASS(0)) u1 (
        .clk(clk), .reset(reset),
        .rd_addr1(v_ra1), .rd_addr2(v_ra2), .rd_data1(v_rd1), .rd_data2(v_rd2),
        .rd_busy1(v_rb1), .rd_busy2(v_rb2),
        .wr_en_a(v_wea), .wr_addr_a(v_waa), .wr_data_a(v_wda),
        .wr_en_b(v_web), .wr_addr_b(v_wab), .wr_data_b(v_wdb),
        .claim_en(v_cle), .claim_addr(v_cla), .collision(v_col)
    );

    typedef struct {
        logic        we;
        logic [2:0]  wa;
        logic [15:0] wd;
        logic [2:0]  r1;
        logic [2:0]  r2;
        logic [15:0] e1;
        logic [15:0] e2;
    } vec_t;
    vec_t tbl[16];

    logic [31:0] mem [32];
    logic        pend_m [32];
    logic        col_m;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", n, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic clr0();
        wea = 0; web = 0; cle = 0;
        waa = 0; wab = 0; cla = 0; wda = 0; wdb = 0;
    endtask

    task automatic clr1();
        v_wea = 0; v_web = 0; v_cle = 0;
        v_waa = 0; v_wab = 0; v_cla = 0; v_wda = 0; v_wdb = 0;
    endtask

    // Spec-level view of a read: r0 is hardwired, this cycle's writes are visible, last writer (B) wins
    task automatic model_read(input logic [4:0] ad, output logic [31:0] d, output logic b);
        logic wa_ok, wb_ok, cl_ok;
        wa_ok = wea && waa != 0;
        wb_ok = web && wab != 0;
        cl_ok = cle && cla != 0;
        d = mem[ad];
        b = pend_m[ad];
        if (wa_ok && waa == ad) begin d = wda; b = cl_ok && cla == ad; end
        if (wb_ok && wab == ad) begin d = wdb; b = cl_ok && cla == ad; end
        if (ad == 0) begin d = 0; b = 0; end
    endtask

    task automatic model_edge();
        logic wa_ok, wb_ok;
        wa_ok = wea && waa != 0;
        wb_ok = web && wab != 0;
        if (wa_ok) begin mem[waa] = wda; pend_m[waa] = 0; end
        if (wb_ok) begin mem[wab] = wdb; pend_m[wab] = 0; end
        if (cle && cla != 0) pend_m[cla] = 1;
        col_m = wa_ok && wb_ok && waa == wab;
    endtask

    initial begin
        logic [31:0] ed;
        logic        eb;
        reset = 0;
        ra1 = 0; ra2 = 0; clr0();
        v_ra1 = 0; v_ra2 = 0; clr1();
        for (int k = 0; k < 8; k++)
            tbl[k] = '{1'b1, 3'(k), 16'(k * 16'h0101), 3'(k), 3'(k + 7), 16'h0,
                       (k == 0) ? 16'h0 : 16'((k - 1) * 16'h0101)};
        for (int k = 8; k < 16; k++)
            tbl[k] = '{1'b0, 3'(k), 16'hFFFF, 3'(k), 3'(15 - k),
                       16'((k - 8) * 16'h0101), 16'((15 - k) * 16'h0101)};
        #12;
        chk("reset_data", rd1, 32'h0);
        chk("reset_col", 32'(col), 32'h0);
        reset = 1;
        tick();

        for (int k = 0; k < 16; k++) begin
            v_wea = tbl[k].we; v_waa = tbl[k].wa; v_wda = tbl[k].wd;
            v_ra1 = tbl[k].r1; v_ra2 = tbl[k].r2;
            settle();
            chk($sformatf("tbl%0d_rd1", k), 32'(v_rd1), 32'(tbl[k].e1));
            chk($sformatf("tbl%0d_rd2", k), 32'(v_rd2), 32'(tbl[k].e2));
            chk($sformatf("tbl%0d_col", k), 32'(v_col), 32'h0);
            tick();
        end
        clr1();

        wea = 1; waa = 3; wda = 32'h1111_1111;
        web = 1; wab = 3; wdb = 32'h2222_2222;
        ra1 = 3;
        settle();
        chk("dual_bypass", rd1, 32'h2222_2222);
        tick(); clr0();
        settle();
        chk("dual_r3", rd1, 32'h2222_2222);
        chk("col_pulse", 32'(col), 32'h1);
        tick();
        chk("col_clear", 32'(col), 32'h0);

        ra1 = 7; wea = 1; waa = 7; wda = 32'h0000_00A5;
        settle();
        chk("byp_data", rd1, 32'h0000_00A5);
        chk("byp_busy", 32'(rb1), 32'h0);
        tick(); clr0();

        cle = 1; cla = 9;
        tick(); clr0();
        ra1 = 9;
        tick(); tick();
        settle();
        chk("claim_busy", 32'(rb1), 32'h1);
        web = 1; wab = 9; wdb = 32'h42;
        settle();
        chk("wb_byp_busy", 32'(rb1), 32'h0);
        chk("wb_byp_data", rd1, 32'h42);
        tick(); clr0();
        settle();
        chk("wb_busy", 32'(rb1), 32'h0);
        chk("wb_data", rd1, 32'h42);
        cle = 1; cla = 9; wea = 1; waa = 9; wda = 32'h77;
        settle();
        chk("cw_byp_busy", 32'(rb1), 32'h1);
        tick(); clr0();
        settle();
        chk("cw_busy", 32'(rb1), 32'h1);
        chk("cw_data", rd1, 32'h77);

        wea = 1; waa = 0; wda = 32'hFFFF_FFFF;
        web = 1; wab = 0; wdb = 32'hFFFF_FFFF;
        cle = 1; cla = 0; ra1 = 0; ra2 = 0;
        settle();
        chk("zero_byp_data", rd1, 32'h0);
        chk("zero_byp_busy", 32'(rb2), 32'h0);
        tick(); clr0();
        settle();
        chk("zero_data", rd1, 32'h0);
        chk("zero_busy", 32'(rb1), 32'h0);
        chk("zero_nocol", 32'(col), 32'h0);

        v_ra1 = 7; v_wea = 1; v_waa = 7; v_wda = 16'h00A5;
        settle();
        chk("nobyp_old", 32'(v_rd1), 32'h0707);
        tick(); clr1();
        settle();
        chk("nobyp_new", 32'(v_rd1), 32'h00A5);
        v_ra1 = 0; v_wea = 1; v_waa = 0; v_wda = 16'hFFFF; v_cle = 1; v_cla = 0;
        settle();
        chk("r0_old", 32'(v_rd1), 32'h0);
        tick(); clr1();
        settle();
        chk("r0_data", 32'(v_rd1), 32'hFFFF);
        chk("r0_busy", 32'(v_rb1), 32'h1);

        wea = 1; waa = 5; wda = 32'h1234;
        web = 1; wab = 5; wdb = 32'hDEAD_BEEF;
        tick(); clr0();
        ra1 = 5;
        settle();
        chk("r5", rd1, 32'hDEAD_BEEF);
        chk("col_before_rst", 32'(col), 32'h1);
        reset = 0;
        #1;
        chk("rst_async_data", rd1, 32'h0);
        chk("rst_async_col", 32'(col), 32'h0);
        chk("rst_async_v", 32'(v_rd1), 32'h0);
        wea = 1; waa = 5; wda = 32'h5555;
        @(posedge clk); #1; clr0();
        settle();
        chk("rst_ignore_edge", rd1, 32'h0);
        reset = 1;
        tick();

        for (int i = 0; i < 32; i++) begin mem[i] = 0; pend_m[i] = 0; end
        col_m = 0;
        for (int n = 0; n < 400; n++) begin
            ra1 = 5'($urandom_range(0, 15)); ra2 = 5'($urandom_range(0, 15));
            wea = 1'($urandom_range(0, 1)); waa = 5'($urandom_range(0, 15)); wda = $urandom;
            web = 1'($urandom_range(0, 1)); wab = 5'($urandom_range(0, 15)); wdb = $urandom;
            cle = 1'($urandom_range(0, 1)); cla = 5'($urandom_range(0, 15));
            settle();
            model_read(ra1, ed, eb);
            chk("rnd_rd1", rd1, ed);
            chk("rnd_busy1", 32'(rb1), 32'(eb));
            model_read(ra2, ed, eb);
            chk("rnd_rd2", rd2, ed);
            chk("rnd_busy2", 32'(rb2), 32'(eb));
            chk("rnd_col", 32'(col), 32'(col_m));
            model_edge();
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
